uart_frame_rx: RTL

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: UART receiver that assembles fixed-length frames onto a valid/ready output
module uart_frame_rx #(
    parameter int CLK_FRE          = 50,
    parameter int BAUD_RATE        = 115200,
    parameter int FRAME_BYTE_WIDTH = 18,
    parameter int TIMEOUT_BITS     = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic [FRAME_BYTE_WIDTH*8-1:0] frame_data,
    output logic                          frame_vld,
    input  logic                          frame_rdy,
    output logic                          frame_err,
    output logic                          frame_tmo,
    output logic                          overrun
);
    localparam int CPB = (CLK_FRE * 1000000) / BAUD_RATE;
    localparam int W   = FRAME_BYTE_WIDTH * 8;
    localparam int TMO = TIMEOUT_BITS * CPB;
    localparam int CW  = $clog2(CPB);
    localparam int GW  = $clog2(TMO + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(TMO);
    localparam logic [7:0]    LAST    = 8'(FRAME_BYTE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    bcnt_q, bcnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [W-1:0]  shift_q, shift_d, data_q, data_d;
    logic          vld_q, vld_d, err_q, err_d, tmo_q, tmo_d, ovr_q, ovr_d;
    logic          rx_s, start_det, tick, done;

    assign rx_s       = sync2_q;
    assign start_det  = (state_q == IDLE) && prev_q && !rx_s;
    assign tick       = cnt_q == ((state_q == START) ? HALF_M1 : FULL_M1);
    assign frame_data = data_q;
    assign frame_vld  = vld_q;
    assign frame_err  = err_q;
    assign frame_tmo  = tmo_q;
    assign overrun    = ovr_q;

    // bit FSM, frame assembly, inter-byte timeout and output handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        bcnt_d  = bcnt_q;
        gap_d   = '0;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = vld_q && !frame_rdy;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        ovr_d   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d = START;
                    cnt_d   = '0;
                end else if (bcnt_q != 8'd0) begin
                    gap_d = gap_q + GW'(1);
                    if (gap_d == GAP_MAX) begin
                        gap_d  = '0;
                        bcnt_d = 8'd0;
                        tmo_d  = 1'b1;
                    end
                end
            end
            START: begin
                if (tick) begin
                    state_d = rx_s ? IDLE : DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    byte_d  = {rx_s, byte_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (rx_s) begin
                        shift_d = W'({shift_q, byte_q});
                        done    = bcnt_q == LAST;
                        bcnt_d  = done ? 8'd0 : bcnt_q + 8'd1;
                    end else begin
                        err_d  = 1'b1;
                        bcnt_d = 8'd0;
                    end
                end
            end
        endcase
        if (done) begin
            ovr_d  = vld_q && !frame_rdy;
            data_d = ovr_d ? data_q : shift_d;
            vld_d  = 1'b1;
        end
    end

    // state registers; the synchronizer idles high so reset never fakes a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            bcnt_q  <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            bcnt_q  <= bcnt_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule
